traffic_junction_ctrl: RTL and testbench
========================================

// Module: traffic_junction_ctrl
// PURPOSE
//  N-approach junction controller; successor to the single-approach traffic FSM. Serves approaches round-robin
//  (GREEN->YELLOW->ALL_RED), latches per-approach pedestrian requests into a shared walk phase, and pre-empts
//  for emergency requests with a safe yellow/all-red clearance first. Drives lamp drivers directly.
// PARAMETERS
//  N_APP       4    number of approaches (2..8)
//  CNT_W       16   phase timer width; timer saturates at all-ones
//  GREEN_TIME  80   cycles of normal green
//  MIN_GREEN   20   green cycles guaranteed before a ped request may cut green short
//  YELLOW_TIME 20   cycles of yellow
//  ALLRED_TIME 10   cycles of all-red clearance
//  PED_TIME    40   cycles of walk phase
//  EMG_TIME    60   minimum cycles of emergency green
// PORTS
//  clk          in   1        rising-edge clock, sole clock
//  reset        in   1        synchronous, active-low (0 = reset, sampled on clk)
//  ped_req      in   N_APP    per-approach ped button; any-cycle high sets latch
//  emg_req      in   N_APP    per-approach emergency request, level; lowest index wins
//  red          out  N_APP    red lamp per approach
//  yellow       out  N_APP    yellow lamp per approach
//  green        out  N_APP    green lamp per approach
//  ped_walk     out  N_APP    walk lamp per approach (latched requesters only)
//  ped_pending  out  N_APP    current pedestrian latches
//  emg_active   out  1        high throughout EMG_GO
//  phase        out  clog2(N_APP)  approach currently or last served
// BEHAVIOUR
//  Reset (reset==0 at edge): state=ALL_RED, timer=0, phase=N_APP-1 (so first green is 0), latches=0,
//   red=all 1, yellow=green=ped_walk=0, emg_active=0. Reset wins over every simultaneous input.
//  Timer: counts cycles in state; reset to 0 on every state change; state with time T lasts exactly T cycles
//   (exit when timer==T-1). Saturates, never wraps.
//  Outputs registered from state/phase; exactly one lamp per approach; at most one green; green only on phase.
//  States:
//   ALL_RED  : all red. On expiry: emergency pending -> EMG_GO(target); else any ped latch -> PED_WALK;
//              else phase<=phase+1 (N_APP-1 wraps to 0), -> GREEN.
//   GREEN    : green[phase]. Expiry -> YELLOW. Ped latch set and timer>=MIN_GREEN-1 -> YELLOW early.
//              Emergency target==phase -> EMG_GO directly (no lamp change). Target!=phase -> YELLOW.
//   YELLOW   : yellow[phase]; on expiry -> ALL_RED. Not shortened by any request.
//   PED_WALK : all red; ped_walk = latches snapshot on entry; on expiry clear served latches, phase<=phase+1,
//              -> GREEN. Emergency -> ALL_RED immediately (timer 0), latches kept, walk off next cycle.
//   EMG_GO   : green[target], phase<=target, emg_active=1. Stay while emg_req[target]==1 or timer<EMG_TIME-1;
//              then -> YELLOW on target; afterwards round-robin resumes at target+1.
//  Emergency target: lowest set bit of emg_req, captured when leaving GREEN/PED_WALK/ALL_RED toward EMG_GO;
//   higher-priority request during EMG_GO does not retarget until next ALL_RED.
//  Ped latch: set by ped_req bit, cleared only on PED_WALK exit or reset; a press in the exit cycle
//   stays set (set wins over clear). Presses during EMG_GO latch normally.
//  Simultaneous ped and emergency: emergency wins; ped latch retained.
//  Never green->red without YELLOW_TIME yellow then ALLRED_TIME all-red, except GREEN->EMG_GO same approach.
// STRUCTURE
//  tfc_pkg: state encoding (ALL_RED, GREEN, YELLOW, PED_WALK, EMG_GO), lamp-vector helper function.
//  Sub-module tfc_prio_enc (N_APP-wide lowest-set-bit encoder: valid + index) for emergency target.
//  Single FSM + timer + latch register bank in the top; no other hierarchy.
// TESTING (N_APP=4, GREEN=8, MIN_GREEN=3, YELLOW=2, ALLRED=2, PED=4, EMG=5)
//  1 Reset low 3 cycles, release, idle -> 2 cyc all-red, green[0] 8 cyc, yellow[0] 2, all-red 2, green[1]..
//    green[3]->green[0] wrap; checker: one-hot-or-zero green every cycle.
//  2 ped_req=4'b0100 pulse at GREEN cycle 1 of phase 0 -> green[0] ends after cycle 3, yellow 2, all-red 2,
//    ped_walk=4'b0100 for 4 cyc, ped_pending clears, then green[1].
//  3 emg_req=4'b1010 during green[0] -> yellow[0] 2, all-red 2, green[1]+emg_active; release after 2 cyc
//    -> green holds to 5 cyc total, yellow[1], all-red, green[2].
//  4 emg_req=4'b0001 during green[0] cycle 4 -> same cycle's next edge emg_active=1, green[0] stays on,
//    no yellow glitch; held 10 cyc -> green 10+ cycles, then yellow[0].
//  5 emg_req asserted during PED_WALK cycle 1 -> all-red next cycle, ped_walk=0, latches kept; after
//    EMG cycle, walk served at the following ALL_RED.
//  6 reset low mid-YELLOW and mid-EMG_GO -> next edge all-red, latches 0, emg_active 0, phase=3.

Source files
------------

// File: rtl/tfc_pkg.sv
// Shared types for the traffic junction controller: FSM state encoding and
// the per-approach lamp selection used to build the registered lamp vectors.
package tfc_pkg;

  typedef enum logic [2:0] {
    ALL_RED,
    GREEN,
    YELLOW,
    PED_WALK,
    EMG_GO
  } tfc_state_e;

  typedef enum logic [1:0] {
    LAMP_RED,
    LAMP_YELLOW,
    LAMP_GREEN
  } lamp_e;

  // Only the served approach ever shows anything other than red.
  function automatic lamp_e lamp_of(tfc_state_e st, logic served);
    lamp_e l;
    l = LAMP_RED;
    if (served) begin
      case (st)
        GREEN, EMG_GO: l = LAMP_GREEN;
        YELLOW:        l = LAMP_YELLOW;
        default:       l = LAMP_RED;
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/tfc_if.sv
// Request inputs and lamp/status outputs of the junction controller, grouped
// as one bundle; the controller is the slave, the request source the master.
interface tfc_if #(
  parameter int N_APP = 4
);
  localparam int PW = $clog2(N_APP);

  logic [N_APP-1:0] ped_req;
  logic [N_APP-1:0] emg_req;
  logic [N_APP-1:0] red;
  logic [N_APP-1:0] yellow;
  logic [N_APP-1:0] green;
  logic [N_APP-1:0] ped_walk;
  logic [N_APP-1:0] ped_pending;
  logic             emg_active;
  logic [PW-1:0]    phase;

  modport master (
    output ped_req, emg_req,
    input  red, yellow, green, ped_walk, ped_pending, emg_active, phase
  );

  modport slave (
    input  ped_req, emg_req,
    output red, yellow, green, ped_walk, ped_pending, emg_active, phase
  );

endinterface

// File: rtl/tfc_prio_enc.sv
// Lowest-set-bit priority encoder: picks the emergency target approach
// (approach 0 has the highest priority).
module tfc_prio_enc #(
  parameter  int W  = 4,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_req,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // NOTE: both outputs get a default before the loop, so no latch is inferred.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// N-approach junction controller: round-robin green/yellow/all-red service,
// latched pedestrian walk phase and emergency pre-emption with safe clearance.
module traffic_junction_ctrl
  import tfc_pkg::*;
#(
  parameter int N_APP       = 4,
  parameter int CNT_W       = 16,
  parameter int GREEN_TIME  = 80,
  parameter int MIN_GREEN   = 20,
  parameter int YELLOW_TIME = 20,
  parameter int ALLRED_TIME = 10,
  parameter int PED_TIME    = 40,
  parameter int EMG_TIME    = 60
) (
  input  logic clk,
  input  logic reset,
  tfc_if.slave bus
);

  localparam int PW = $clog2(N_APP);

  localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] T_MIN    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] T_PED    = CNT_W'(PED_TIME - 1);
  localparam logic [CNT_W-1:0] T_EMG    = CNT_W'(EMG_TIME - 1);

  typedef struct packed {
    logic [N_APP-1:0] red;
    logic [N_APP-1:0] yellow;
    logic [N_APP-1:0] green;
  } lamp_vec_t;

  function automatic lamp_vec_t lamp_vec(tfc_state_e st, logic [PW-1:0] idx);
    lamp_vec_t v;
    v = '0;
    for (int a = 0; a < N_APP; a++) begin
      case (lamp_of(st, PW'(a) == idx))
        LAMP_GREEN:  v.green[a]  = 1'b1;
        LAMP_YELLOW: v.yellow[a] = 1'b1;
        default:     v.red[a]    = 1'b1;
      endcase
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] next_phase(logic [PW-1:0] p);
    return (p == PW'(N_APP - 1)) ? '0 : p + 1'b1;
  endfunction

  tfc_state_e       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [PW-1:0]    r_phase;
  logic [N_APP-1:0] r_ped;
  logic [N_APP-1:0] r_walk;
  logic             r_emg_act;
  lamp_vec_t        r_lamps;

  logic             w_emg_valid;
  logic [PW-1:0]    w_emg_idx;

  tfc_prio_enc #(.W(N_APP)) u_prio (
    .i_req   (bus.emg_req),
    .o_valid (w_emg_valid),
    .o_idx   (w_emg_idx)
  );

  // NOTE: non-blocking assignments only; a later assignment in a branch
  // overrides the default timer/latch update made at the top of the block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ALL_RED;
      r_timer   <= '0;
      r_phase   <= PW'(N_APP - 1);
      r_ped     <= '0;
      r_walk    <= '0;
      r_emg_act <= 1'b0;
      r_lamps   <= lamp_vec(ALL_RED, '0);
    end else begin
      r_timer <= (&r_timer) ? r_timer : r_timer + 1'b1;
      r_ped   <= r_ped | bus.ped_req;

      case (r_state)
        ALL_RED: begin
          if (r_timer == T_ALLRED) begin
            r_timer <= '0;
            if (w_emg_valid) begin
              r_state   <= EMG_GO;
              r_phase   <= w_emg_idx;
              r_emg_act <= 1'b1;
              r_lamps   <= lamp_vec(EMG_GO, w_emg_idx);
            end else if (|r_ped) begin
              r_state <= PED_WALK;
              r_walk  <= r_ped;
            end else begin
              r_state <= GREEN;
              r_phase <= next_phase(r_phase);
              r_lamps <= lamp_vec(GREEN, next_phase(r_phase));
            end
          end
        end

        GREEN: begin
          // Same-approach emergency keeps the green lit: no clearance needed.
          if (w_emg_valid && (w_emg_idx == r_phase)) begin
            r_state   <= EMG_GO;
            r_timer   <= '0;
            r_emg_act <= 1'b1;
          end else if (w_emg_valid || (r_timer == T_GREEN) ||
                       ((|r_ped) && (r_timer >= T_MIN))) begin
            r_state <= YELLOW;
            r_timer <= '0;
            r_lamps <= lamp_vec(YELLOW, r_phase);
          end
        end

        YELLOW: begin
          if (r_timer == T_YELLOW) begin
            r_state <= ALL_RED;
            r_timer <= '0;
            r_lamps <= lamp_vec(ALL_RED, r_phase);
          end
        end

        PED_WALK: begin
          if (w_emg_valid) begin
            r_state <= ALL_RED;
            r_timer <= '0;
            r_walk  <= '0;
          end else if (r_timer == T_PED) begin
            // A press in this very cycle survives the clear.
            r_ped   <= (r_ped & ~r_walk) | bus.ped_req;
            r_walk  <= '0;
            r_state <= GREEN;
            r_timer <= '0;
            r_phase <= next_phase(r_phase);
            r_lamps <= lamp_vec(GREEN, next_phase(r_phase));
          end
        end

        EMG_GO: begin
          if (!bus.emg_req[r_phase] && (r_timer >= T_EMG)) begin
            r_state   <= YELLOW;
            r_timer   <= '0;
            r_emg_act <= 1'b0;
            r_lamps   <= lamp_vec(YELLOW, r_phase);
          end
        end

        default: begin
          r_state   <= ALL_RED;
          r_timer   <= '0;
          r_walk    <= '0;
          r_emg_act <= 1'b0;
          r_lamps   <= lamp_vec(ALL_RED, r_phase);
        end
      endcase
    end
  end

  assign bus.red         = r_lamps.red;
  assign bus.yellow      = r_lamps.yellow;
  assign bus.green       = r_lamps.green;
  assign bus.ped_walk    = r_walk;
  assign bus.ped_pending = r_ped;
  assign bus.emg_active  = r_emg_act;
  assign bus.phase       = r_phase;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Directed bench for the junction controller: per-scenario tasks walk a
// hand-written cycle-by-cycle expectation table, plus a lamp-safety monitor.
module tb_traffic_junction_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  tfc_if #(.N_APP(4)) bus ();

  traffic_junction_ctrl #(
    .N_APP(4), .CNT_W(8), .GREEN_TIME(8), .MIN_GREEN(3), .YELLOW_TIME(2),
    .ALLRED_TIME(2), .PED_TIME(4), .EMG_TIME(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [3:0] w;
    logic [3:0] p;
    logic       e;
    logic [1:0] ph;
  } obs_t;

  localparam int K_AR = 0;
  localparam int K_G  = 1;
  localparam int K_Y  = 2;
  localparam logic [3:0] NONE = 4'b0000;

  // Expected observation: lamp kind k on approach a, walk w, pending p, emg e, phase ph.
  function automatic obs_t ex(int k, int a, logic [3:0] w, logic [3:0] p, logic e, int ph);
    obs_t o;
    logic [3:0] lit;
    lit  = 4'b0001 << a;
    o.r  = (k == K_AR) ? 4'hF : ~lit;
    o.y  = (k == K_Y) ? lit : 4'h0;
    o.g  = (k == K_G) ? lit : 4'h0;
    o.w  = w;
    o.p  = p;
    o.e  = e;
    o.ph = 2'(ph);
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_pending, bus.emg_active, bus.phase};
  endfunction

  // Every cycle: exactly one lamp per approach, at most one green overall.
  always @(negedge clk) begin
    n_total++;
    if ((((bus.red & bus.yellow) | (bus.red & bus.green) | (bus.yellow & bus.green)) !== 4'h0) ||
        ((bus.red | bus.yellow | bus.green) !== 4'hF) || ($countones(bus.green) > 1)) begin
      n_bad++;
      $display("FAIL lamp_safety t=%0t: r=%b y=%b g=%b, required one lamp per approach, <=1 green",
               $time, bus.red, bus.yellow, bus.green);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    bus.ped_req = '0;
    bus.emg_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    reset       = 1'b0;
    bus.ped_req = 4'b1111;
    bus.emg_req = 4'b0001;
    repeat (3) @(negedge clk);
    got  = sample();
    want = ex(K_AR, 0, NONE, NONE, 1'b0, 3);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_state: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
               got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
               want.r, want.y, want.g, want.w, want.p, want.e, want.ph);
    end
    bus.ped_req = '0;
    bus.emg_req = '0;
    reset       = 1'b1;
  endtask

  task automatic test_round_robin();
    obs_t q[$];
    obs_t got;
    do_reset();
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    for (int a = 0; a < 4; a++) begin
      repeat (8) q.push_back(ex(K_G, a, NONE, NONE, 1'b0, a));
      repeat (2) q.push_back(ex(K_Y, a, NONE, NONE, 1'b0, a));
      repeat (2) q.push_back(ex(K_AR, a, NONE, NONE, 1'b0, a));
    end
    q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = sample();
      n_total++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL round_robin step %0d: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
                 i, got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
                 q[i].r, q[i].y, q[i].g, q[i].w, q[i].p, q[i].e, q[i].ph);
      end
    end
  endtask

  task automatic test_ped_walk();
    obs_t q[$];
    obs_t got;
    logic [3:0] pp;
    pp = 4'b0100;
    do_reset();
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    repeat (2) q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    q.push_back(ex(K_G, 0, NONE, pp, 1'b0, 0));
    repeat (2) q.push_back(ex(K_Y, 0, NONE, pp, 1'b0, 0));
    repeat (2) q.push_back(ex(K_AR, 0, NONE, pp, 1'b0, 0));
    repeat (4) q.push_back(ex(K_AR, 0, pp, pp, 1'b0, 0));
    q.push_back(ex(K_G, 1, NONE, NONE, 1'b0, 1));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = sample();
      n_total++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL ped_walk step %0d: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
                 i, got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
                 q[i].r, q[i].y, q[i].g, q[i].w, q[i].p, q[i].e, q[i].ph);
      end
      case (i)
        2:       bus.ped_req = pp;
        3:       bus.ped_req = '0;
        default: ;
      endcase
    end
  endtask

  task automatic test_emg_other();
    obs_t q[$];
    obs_t got;
    do_reset();
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    repeat (2) q.push_back(ex(K_Y, 0, NONE, NONE, 1'b0, 0));
    repeat (2) q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 0));
    repeat (5) q.push_back(ex(K_G, 1, NONE, NONE, 1'b1, 1));
    repeat (2) q.push_back(ex(K_Y, 1, NONE, NONE, 1'b0, 1));
    repeat (2) q.push_back(ex(K_AR, 1, NONE, NONE, 1'b0, 1));
    q.push_back(ex(K_G, 2, NONE, NONE, 1'b0, 2));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = sample();
      n_total++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL emg_other step %0d: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
                 i, got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
                 q[i].r, q[i].y, q[i].g, q[i].w, q[i].p, q[i].e, q[i].ph);
      end
      case (i)
        1:       bus.emg_req = 4'b1010;
        7:       bus.emg_req = '0;
        default: ;
      endcase
    end
  endtask

  task automatic test_emg_same();
    obs_t q[$];
    obs_t got;
    do_reset();
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    repeat (5) q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    repeat (10) q.push_back(ex(K_G, 0, NONE, NONE, 1'b1, 0));
    repeat (2) q.push_back(ex(K_Y, 0, NONE, NONE, 1'b0, 0));
    repeat (2) q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 0));
    q.push_back(ex(K_G, 1, NONE, NONE, 1'b0, 1));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = sample();
      n_total++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL emg_same step %0d: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
                 i, got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
                 q[i].r, q[i].y, q[i].g, q[i].w, q[i].p, q[i].e, q[i].ph);
      end
      case (i)
        5:       bus.emg_req = 4'b0001;
        15:      bus.emg_req = '0;
        default: ;
      endcase
    end
  endtask

  task automatic test_emg_during_walk();
    obs_t q[$];
    obs_t got;
    logic [3:0] pp;
    pp = 4'b0100;
    do_reset();
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    repeat (2) q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    q.push_back(ex(K_G, 0, NONE, pp, 1'b0, 0));
    repeat (2) q.push_back(ex(K_Y, 0, NONE, pp, 1'b0, 0));
    repeat (2) q.push_back(ex(K_AR, 0, NONE, pp, 1'b0, 0));
    repeat (2) q.push_back(ex(K_AR, 0, pp, pp, 1'b0, 0));
    repeat (2) q.push_back(ex(K_AR, 0, NONE, pp, 1'b0, 0));
    repeat (5) q.push_back(ex(K_G, 1, NONE, pp, 1'b1, 1));
    repeat (2) q.push_back(ex(K_Y, 1, NONE, pp, 1'b0, 1));
    repeat (2) q.push_back(ex(K_AR, 1, NONE, pp, 1'b0, 1));
    repeat (4) q.push_back(ex(K_AR, 1, pp, pp, 1'b0, 1));
    q.push_back(ex(K_G, 2, NONE, NONE, 1'b0, 2));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = sample();
      n_total++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL emg_walk step %0d: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
                 i, got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
                 q[i].r, q[i].y, q[i].g, q[i].w, q[i].p, q[i].e, q[i].ph);
      end
      case (i)
        2:       bus.ped_req = pp;
        3:       bus.ped_req = '0;
        9:       bus.emg_req = 4'b0010;
        12:      bus.emg_req = '0;
        default: ;
      endcase
    end
  endtask

  task automatic test_mid_reset();
    obs_t q[$];
    obs_t got;
    do_reset();
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    repeat (2) q.push_back(ex(K_G, 0, NONE, 4'b0001, 1'b0, 0));
    q.push_back(ex(K_Y, 0, NONE, 4'b0001, 1'b0, 0));
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    q.push_back(ex(K_G, 0, NONE, NONE, 1'b0, 0));
    q.push_back(ex(K_G, 0, NONE, NONE, 1'b1, 0));
    q.push_back(ex(K_G, 0, NONE, 4'b0010, 1'b1, 0));
    q.push_back(ex(K_AR, 0, NONE, NONE, 1'b0, 3));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      got = sample();
      n_total++;
      if (got !== q[i]) begin
        n_bad++;
        $display("FAIL mid_reset step %0d: got r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d, want r=%b y=%b g=%b w=%b p=%b e=%b ph=%0d",
                 i, got.r, got.y, got.g, got.w, got.p, got.e, got.ph,
                 q[i].r, q[i].y, q[i].g, q[i].w, q[i].p, q[i].e, q[i].ph);
      end
      case (i)
        1:       bus.ped_req = 4'b0001;
        2:       bus.ped_req = '0;
        4:       reset = 1'b0;
        5:       reset = 1'b1;
        7:       bus.emg_req = 4'b0001;
        8:       bus.ped_req = 4'b0010;
        9: begin
          bus.ped_req = '0;
          reset       = 1'b0;
        end
        10: begin
          reset       = 1'b1;
          bus.emg_req = '0;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.ped_req = '0;
    bus.emg_req = '0;
    test_reset();
    test_round_robin();
    test_ped_walk();
    test_emg_other();
    test_emg_same();
    test_emg_during_walk();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
